// File: rtl/cpr_pkg.sv
// Shared widths and the result-entry payload for the compressor scheduler.
package cpr_pkg;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned TAG_W   = 16;
    localparam int unsigned ID_W    = 1;
    localparam int unsigned NUM_REQ = 2;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [ID_W-1:0]   id;
    } cpr_entry_t;

endpackage

// File: rtl/cpr_result_fifo.sv
// First-word-fall-through result FIFO; a same-edge read frees the slot a full write needs.
module cpr_result_fifo
    import cpr_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = cpr_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   wr_en,
    input  entry_t wr_entry,
    input  logic   rd_en,
    output entry_t rd_entry,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          rd_fire;
    logic          wr_fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Credits upstream must make an unmatched write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && full && !rd_fire));

endmodule

// File: rtl/cpr_scheduler.sv
// Two-requester round-robin front end for a fixed-latency line compressor,
// with credit-based flow control into an in-order result FIFO.
module cpr_scheduler
    import cpr_pkg::*;
#(
    parameter int unsigned CPR_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [LINE_W-1:0] req_data0,
    input  logic [LINE_W-1:0] req_data1,
    output logic              cpr_wrtEn,
    output logic [LINE_W-1:0] cpr_dataIn,
    input  logic [LINE_W-1:0] cpr_dataOut,
    input  logic [TAG_W-1:0]  cpr_tagOut,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [ID_W-1:0]   out_id,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PIPE_D = CPR_LAT + 1;

    logic [CNT_W-1:0]             outstanding;
    logic                         rr;
    logic                         accept;
    logic [ID_W-1:0]              acc_id;
    logic                         out_fire;
    logic [PIPE_D-1:0]            vld_pipe;
    logic [PIPE_D-1:0][ID_W-1:0]  id_pipe;
    cpr_entry_t                   wr_entry;
    cpr_entry_t                   rd_entry;
    logic                         fifo_empty;

    // Round-robin grant, gated by available credits and held off during reset.
    always_comb begin
        req_ready = 2'b00;
        if (!reset && (outstanding < CNT_W'(FIFO_DEPTH))) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign acc_id   = ID_W'(req_ready[1]);
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr          <= 1'b0;
            outstanding <= '0;
            cpr_wrtEn   <= 1'b0;
            cpr_dataIn  <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
        end else begin
            cpr_wrtEn   <= accept;
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(out_fire);
            // Pipeline stage k holds the accept from k edges ago; last stage meets compressor output.
            vld_pipe    <= {vld_pipe[PIPE_D-2:0], accept};
            id_pipe     <= {id_pipe[PIPE_D-2:0], acc_id};
            if (accept) begin
                cpr_dataIn <= req_ready[1] ? req_data1 : req_data0;
                rr         <= ~req_ready[1];
            end
        end
    end

    assign wr_entry = '{data: cpr_dataOut, tag: cpr_tagOut, id: id_pipe[PIPE_D-1]};

    cpr_result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (cpr_entry_t)
    ) u_result_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (vld_pipe[PIPE_D-1]),
        .wr_entry (wr_entry),
        .rd_en    (out_ready),
        .rd_entry (rd_entry),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = rd_entry.data;
    assign out_tag   = rd_entry.tag;
    assign out_id    = rd_entry.id;
    assign busy      = (outstanding != '0);

endmodule

// File: tb/tb_cpr_scheduler.sv
// Scoreboarded random/directed bench for cpr_scheduler with a one-cycle compressor model.
module tb_cpr_scheduler;
    import cpr_pkg::*;

    localparam int unsigned CPR_LAT = 1;
    localparam int unsigned DEPTH   = 4;
    localparam logic [255:0] LINE_A =
        256'h1200_0000_0000_0000_3400_0000_5678_0000_9ABC_DEF1_2300_0000_4567_0000_89AB_CDEF;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [LINE_W-1:0] req_data0;
    logic [LINE_W-1:0] req_data1;
    logic              cpr_wrtEn;
    logic [LINE_W-1:0] cpr_dataIn;
    logic [LINE_W-1:0] cpr_dataOut = '0;
    logic [TAG_W-1:0]  cpr_tagOut = '0;
    logic              out_valid;
    logic              out_ready;
    logic [LINE_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [ID_W-1:0]   out_id;
    logic              busy;

    cpr_scheduler #(.CPR_LAT(CPR_LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .cpr_wrtEn   (cpr_wrtEn),
        .cpr_dataIn  (cpr_dataIn),
        .cpr_dataOut (cpr_dataOut),
        .cpr_tagOut  (cpr_tagOut),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_id      (out_id),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Word classes: 00 zero, 01 only top byte, 10 only top half, 11 raw.
    function automatic logic [1:0] word_code(input logic [31:0] w);
        if (w == 32'h0) return 2'b00;
        if (w[23:0] == 24'h0) return 2'b01;
        if (w[15:0] == 16'h0) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [15:0] cmp_tag(input logic [255:0] l);
        logic [15:0] t;
        for (int i = 0; i < 8; i++) t[2*i +: 2] = word_code(l[32*i +: 32]);
        return t;
    endfunction

    function automatic logic [255:0] cmp_data(input logic [255:0] l);
        logic [255:0] d;
        logic [31:0]  w;
        int           pos;
        d   = '0;
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            w = l[32*i +: 32];
            case (word_code(w))
                2'b01:   begin d[pos +: 8]  = w[31:24]; pos += 8;  end
                2'b10:   begin d[pos +: 16] = w[31:16]; pos += 16; end
                2'b11:   begin d[pos +: 32] = w;        pos += 32; end
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        logic [31:0]  w;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(3))
                0:       w = 32'h0;
                1:       w = {8'($urandom_range(1, 255)), 24'h0};
                2:       w = {16'($urandom_range(1, 65535)), 16'h0};
                default: w = $urandom;
            endcase
            l[32*i +: 32] = w;
        end
        return l;
    endfunction

    // Compressor model: result registered one edge after the write-enable cycle.
    always @(posedge clk) begin
        if (cpr_wrtEn) begin
            cpr_dataOut <= cmp_data(cpr_dataIn);
            cpr_tagOut  <= cmp_tag(cpr_dataIn);
        end
    end

    // Reference model state
    cpr_entry_t   sb[$];
    int           pend[$];
    int           m_out;
    bit           m_rr;
    bit           m_wr;
    logic [255:0] m_line;
    int           cyc;
    logic [1:0]   last_ready;

    task automatic model_clear();
        sb.delete();
        pend.delete();
        m_out  = 0;
        m_rr   = 1'b0;
        m_wr   = 1'b0;
        m_line = '0;
    endtask

    // One clock of stimulus: check against the model at negedge, advance model at posedge.
    task automatic step();
        logic [1:0] g;
        bit         m_valid;
        bit         hs;
        cpr_entry_t e;
        @(negedge clk);
        g = 2'b00;
        if (m_out < int'(DEPTH)) begin
            case (req_valid)
                2'b01:   g = 2'b01;
                2'b10:   g = 2'b10;
                2'b11:   g = m_rr ? 2'b10 : 2'b01;
                default: g = 2'b00;
            endcase
        end
        last_ready = req_ready;
        m_valid    = (pend.size() > 0) && (pend[0] <= cyc);
        check("req_ready", 256'(req_ready), 256'(g));
        check("out_valid", 256'(out_valid), 256'(m_valid));
        check("busy", 256'(busy), 256'(m_out != 0));
        check("cpr_wrtEn", 256'(cpr_wrtEn), 256'(m_wr));
        check("cpr_dataIn", cpr_dataIn, m_line);
        hs = m_valid && out_ready;
        @(posedge clk);
        cyc++;
        m_wr = (g != 2'b00);
        if (g != 2'b00) begin
            m_line = g[1] ? req_data1 : req_data0;
            e.data = cmp_data(m_line);
            e.tag  = cmp_tag(m_line);
            e.id   = ID_W'(g[1]);
            sb.push_back(e);
            pend.push_back(cyc + int'(CPR_LAT) + 1);
            m_rr = ~g[1];
        end
        if (hs) void'(pend.pop_front());
        m_out += int'(g != 2'b00) - int'(hs);
        #1;
    endtask

    task automatic drain();
        int n;
        req_valid = 2'b00;
        out_ready = 1'b1;
        n = 0;
        while ((m_out > 0) && (n < 40)) begin
            step();
            n++;
        end
        check("drain_done", 256'(m_out), 256'(0));
        step();
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks hold stability otherwise.
    initial begin
        cpr_entry_t   e;
        bit           hold;
        logic [255:0] h_data;
        logic [15:0]  h_tag;
        logic [0:0]   h_id;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 256'(out_valid), 256'(1'b1));
                    check("hold_data", out_data, h_data);
                    check("hold_tag", 256'(out_tag), 256'(h_tag));
                    check("hold_id", 256'(out_id), 256'(h_id));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("out_unexpected", 256'(out_valid), 256'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_tag", 256'(out_tag), 256'(e.tag));
                        check("out_id", 256'(out_id), 256'(e.id));
                    end
                end
                hold   = out_valid && !out_ready;
                h_data = out_data;
                h_tag  = out_tag;
                h_id   = out_id;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        out_ready = 1'b0;
        cyc       = 0;
        last_ready = 2'b00;
        model_clear();
        repeat (2) @(posedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 256'(req_ready), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_wrtEn", 256'(cpr_wrtEn), 256'(0));
        check("rst_dataIn", cpr_dataIn, 256'(0));
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;

        // Contention: six alternating grants starting with requester 0.
        out_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            req_data0 = rand_line();
            req_data1 = rand_line();
            step();
            check("contend_grant", 256'(last_ready), 256'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        drain();

        // Single line with the reference tag.
        req_valid = 2'b01;
        req_data0 = LINE_A;
        step();
        req_valid = 2'b00;
        step();
        check("single_early", 256'(out_valid), 256'(0));
        step();
        check("single_valid", 256'(out_valid), 256'(1));
        check("single_tag", 256'(out_tag), 256'(16'b0100011011011011));
        check("single_id", 256'(out_id), 256'(0));
        drain();

        // Backpressure: four credits, then one more per output pulse.
        out_ready = 1'b0;
        req_valid = 2'b01;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_data0 = rand_line();
            step();
            acc += int'(last_ready[0]);
        end
        check("bp_accepts", 256'(acc), 256'(4));
        check("bp_ready_low", 256'(req_ready), 256'(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_data0 = rand_line();
            step();
            acc += int'(last_ready[0]);
        end
        check("bp_one_more", 256'(acc), 256'(1));

        // Full FIFO with output handshake and req1 pending on the same edge.
        req_valid = 2'b10;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_data1 = rand_line();
            step();
        end
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom_range(3));
            req_data0 = rand_line();
            req_data1 = rand_line();
            out_ready = ($urandom_range(9) < 7);
            step();
        end
        drain();

        // Reset with three lines in flight.
        out_ready = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_data0 = rand_line();
            step();
        end
        reset = 1'b1;
        req_valid = 2'b00;
        #1;
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_wrtEn", 256'(cpr_wrtEn), 256'(0));
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        req_valid = 2'b11;
        req_data0 = rand_line();
        req_data1 = rand_line();
        step();
        check("post_rst_grant", 256'(last_ready), 256'(2'b01));
        step();
        drain();
        check("sb_empty", 256'(sb.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpr_scheduler.md
CPR_SCHEDULER -- requirements
Module: cpr_scheduler

Interface
REQ-001 Parameter CPR_LAT, default 1: fixed compressor latency, in cycles, from the cycle cpr_wrtEn is high to the rising edge at which cpr_dataOut/cpr_tagOut are valid; legal range 1..8.
REQ-002 Parameter FIFO_DEPTH, default 4: number of result FIFO entries; power of two; at least CPR_LAT+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester line valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; combinational; one-hot or zero.
REQ-007 req_data0, req_data1  input  256 each  uncompressed 32-byte lines, one per requester.
REQ-008 cpr_wrtEn  output  1  compressor write enable; registered.
REQ-009 cpr_dataIn  output  256  line to the compressor; registered.
REQ-010 cpr_dataOut  input  256  compressed line from the compressor.
REQ-011 cpr_tagOut  input  16  compressor tag, 2 bits per 32-bit word.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  256  compressed line.
REQ-015 out_tag  output  16  tag for out_data.
REQ-016 out_id  output  1  requester index that owns the result.
REQ-017 busy  output  1  high while outstanding is non-zero.

Function
REQ-018 Credit counter "outstanding", width clog2(FIFO_DEPTH+1), counts accepted lines that have not yet left through the output handshake.
REQ-019 Grant allowed only when outstanding < FIFO_DEPTH; when outstanding = FIFO_DEPTH, req_ready = 0.
REQ-020 Round-robin arbitration:
- one valid requester: that requester is granted;
- both valid: grant goes to the requester named by pointer rr;
- after any grant, rr points to the requester that was not granted.
REQ-021 Accept = req_valid[i] & req_ready[i] at a rising edge E; cpr_wrtEn = 1 and cpr_dataIn = req_data[i] during the cycle after E; cpr_wrtEn = 0 in cycles with no accept, and cpr_dataIn holds its last value.
REQ-022 A valid/ID shift pipeline of depth 1+CPR_LAT tracks each accept; at edge E+1+CPR_LAT the FIFO writes {cpr_dataOut, cpr_tagOut, id}.
REQ-023 Result FIFO is first-word-fall-through; out_valid = FIFO not empty; out_data, out_tag and out_id come from the head entry and stay stable while out_valid & !out_ready.
REQ-024 Minimum accept-to-out_valid latency is 1+CPR_LAT cycles; results leave strictly in accept order.
REQ-025 Same-edge accept and output handshake: outstanding is unchanged; FIFO write and read in the same edge are both honoured, including when the FIFO is full.
REQ-026 The credit rule guarantees the FIFO never overflows; a write into a full FIFO is a design error and is flagged by an assertion.
REQ-027 Back-to-back accepts are sustained at one per cycle while credits remain.

Reset
REQ-028 While reset is high:
- outstanding, rr, the valid pipeline and the FIFO pointers are cleared to 0;
- cpr_wrtEn, cpr_dataIn, out_valid and busy read 0;
- req_ready reads 0.
REQ-029 Reset mid-operation discards all in-flight and queued results; compressor outputs returning after reset release are ignored because the valid pipeline is cleared.
REQ-030 rr = 0 after reset, so requester 0 wins the first contention.

Structure
REQ-031 Package cpr_pkg holds LINE_W = 256, TAG_W = 16, ID_W = 1, and the result-entry struct {data, tag, id}.
REQ-032 The result FIFO is a separate sub-module, cpr_result_fifo, parameterised by depth and entry type; the arbiter, credit counter and pipeline stay in cpr_scheduler.

Verification
REQ-033 The bench uses a compressor model with CPR_LAT = 1.
REQ-034 Single line:
- stimulus: req0 sends 256'h1200_0000_0000_0000_3400_0000_5678_0000_9ABC_DEF1_2300_0000_4567_0000_89AB_CDEF, out_ready = 1;
- response: cpr_wrtEn high one cycle after accept; out_valid high 2 cycles after accept; out_id = 0; out_tag equals the model's tag (16'b0100011011011011 for this line).
REQ-035 Contention:
- stimulus: both requesters valid continuously for 6 cycles;
- response: grants alternate 0,1,0,1,0,1; out_id follows the same sequence.
REQ-036 Backpressure:
- stimulus: out_ready = 0, req0 streams lines;
- response: exactly 4 accepts, then req_ready = 0; a single out_ready pulse yields exactly one further accept.
REQ-037 Full with simultaneous events:
- stimulus: outstanding = 4; out_ready and req1 valid high on the same edge;
- response: outstanding stays 4; FIFO order is preserved.
REQ-038 Reset mid-flight:
- stimulus: assert reset with 3 lines outstanding;
- response: out_valid, busy and cpr_wrtEn are 0 immediately; no result appears after release; the next contention grants req0.
